// File: rtl/dual_port_memory_ctrl.sv
// Simple-dual-port scratchpad memory: one write port and one read port, each able to
// accept a request every cycle once the power-on clear sequence has finished.
//
// Ports:
//   clk, reset         rising-edge clock; synchronous active-high reset
//   wr_valid/wr_ready  write handshake; wr_addr, wr_data, wr_be (byte lane enables)
//   rd_valid/rd_ready  read handshake; rd_addr
//   rd_data            read result, held between results
//   rd_data_valid      one-cycle pulse RD_LATENCY cycles after a read is accepted
//   init_busy          high while the clear sequence walks every word to zero
//   addr_err           one-cycle pulse the cycle after an out-of-range access is accepted
module dual_port_memory_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 12,
  parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
  parameter int unsigned BE_WIDTH    = WIDTH / 8,
  parameter int unsigned RD_LATENCY  = 1,
  parameter bit          WRITE_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_data_valid,
  output logic                  init_busy,
  output logic                  addr_err
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [ADDR_WIDTH:0]   DepthExt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_acc, rd_acc;
  logic             wr_in_range, rd_in_range;
  logic             collide;
  logic [WIDTH-1:0] old_word, merged_word, rd_word;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             rd_data_valid_q, addr_err_q;
  logic [WIDTH-1:0] rd_data_q;

  // Clear-sequence FSM
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StInit: begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
        if (ptr_q == LastAddr) begin
          state_d = StRun;
          ptr_d   = '0;
        end
      end
      StRun:   ;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StInit;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign init_busy = (state_q == StInit);
  assign wr_ready  = (state_q == StRun);
  assign rd_ready  = (state_q == StRun);

  assign wr_acc      = wr_valid & wr_ready;
  assign rd_acc      = rd_valid & rd_ready;
  assign wr_in_range = ({1'b0, wr_addr} < DepthExt);
  assign rd_in_range = ({1'b0, rd_addr} < DepthExt);

  // Storage: the clear sequence owns the array during INIT, the write port afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StInit) begin
        mem[ptr_q] <= '0;
      end else if (wr_acc && wr_in_range) begin
        for (int i = 0; i < int'(BE_WIDTH); i++) begin
          if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Read word, including same-cycle write forwarding in write-first mode.
  always_comb begin
    old_word    = rd_in_range ? mem[rd_addr] : '0;
    merged_word = old_word;
    for (int i = 0; i < int'(BE_WIDTH); i++) begin
      if (wr_be[i]) merged_word[8*i +: 8] = wr_data[8*i +: 8];
    end
    collide = wr_acc & wr_in_range & rd_in_range & (wr_addr == rd_addr);
    rd_word = (WRITE_FIRST && collide) ? merged_word : old_word;
  end

  // Optional extra pipeline stage for RD_LATENCY == 2
  if (RD_LATENCY == 2) begin : g_lat2
    logic             pipe_valid_q;
    logic [WIDTH-1:0] pipe_data_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        pipe_valid_q <= 1'b0;
        pipe_data_q  <= '0;
      end else begin
        pipe_valid_q <= rd_acc;
        pipe_data_q  <= rd_word;
      end
    end

    assign out_valid = pipe_valid_q;
    assign out_data  = pipe_data_q;
  end else begin : g_lat1
    assign out_valid = rd_acc;
    assign out_data  = rd_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_valid_q <= 1'b0;
      rd_data_q       <= '0;
      addr_err_q      <= 1'b0;
    end else begin
      rd_data_valid_q <= out_valid;
      if (out_valid) rd_data_q <= out_data;
      // Both ports out of range together still yields a single pulse.
      addr_err_q <= (wr_acc & ~wr_in_range) | (rd_acc & ~rd_in_range);
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;
  assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_dual_port_memory_ctrl.sv
// Directed bench for dual_port_memory_ctrl. Two instances share the stimulus:
// instance a uses RD_LATENCY=1/WRITE_FIRST=1, instance b uses RD_LATENCY=2/WRITE_FIRST=0.
module tb_dual_port_memory_ctrl;

  logic        clk;
  logic        reset;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_valid;
  logic [3:0]  rd_addr;

  logic        wr_ready_a, rd_ready_a, rd_data_valid_a, init_busy_a, addr_err_a;
  logic        wr_ready_b, rd_ready_b, rd_data_valid_b, init_busy_b, addr_err_b;
  logic [31:0] rd_data_a, rd_data_b;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] exp_img [12];

  dual_port_memory_ctrl #(
    .WIDTH(32), .DEPTH(12), .RD_LATENCY(1), .WRITE_FIRST(1'b1)
  ) u_dut_a (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_valid(rd_valid), .rd_ready(rd_ready_a), .rd_addr(rd_addr),
    .rd_data(rd_data_a), .rd_data_valid(rd_data_valid_a), .init_busy(init_busy_a),
    .addr_err(addr_err_a)
  );

  dual_port_memory_ctrl #(
    .WIDTH(32), .DEPTH(12), .RD_LATENCY(2), .WRITE_FIRST(1'b0)
  ) u_dut_b (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_valid(rd_valid), .rd_ready(rd_ready_b), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_data_valid(rd_data_valid_b), .init_busy(init_busy_b),
    .addr_err(addr_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called right after the reset edge with reset already released.
  task automatic wait_init();
    for (int i = 0; i < 12; i++) begin
      chk("init_busy_a", {31'd0, init_busy_a}, 32'd1);
      chk("init_busy_b", {31'd0, init_busy_b}, 32'd1);
      chk("wr_ready_a_init", {31'd0, wr_ready_a}, 32'd0);
      chk("rd_ready_b_init", {31'd0, rd_ready_b}, 32'd0);
      chk("rdv_a_init", {31'd0, rd_data_valid_a}, 32'd0);
      chk("rdv_b_init", {31'd0, rd_data_valid_b}, 32'd0);
      step();
    end
    chk("init_done_a", {31'd0, init_busy_a}, 32'd0);
    chk("init_done_b", {31'd0, init_busy_b}, 32'd0);
    chk("wr_ready_a", {31'd0, wr_ready_a}, 32'd1);
    chk("rd_ready_a", {31'd0, rd_ready_a}, 32'd1);
    chk("wr_ready_b", {31'd0, wr_ready_b}, 32'd1);
    chk("rd_ready_b", {31'd0, rd_ready_b}, 32'd1);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
    step();
    wr_valid = 1'b0;
  endtask

  // Back-to-back reads of every address, checked against exp_img.
  task automatic read_all();
    for (int i = 0; i < 14; i++) begin
      rd_valid = (i < 12);
      rd_addr  = 4'(i);
      step();
      chk("all_rdv_a", {31'd0, rd_data_valid_a}, {31'd0, i < 12});
      if (i < 12) chk("all_data_a", rd_data_a, exp_img[i]);
      chk("all_rdv_b", {31'd0, rd_data_valid_b}, {31'd0, (i >= 1) && (i <= 12)});
      if ((i >= 1) && (i <= 12)) chk("all_data_b", rd_data_b, exp_img[i-1]);
    end
    rd_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_be    = '0;
    rd_valid = 1'b0;
    rd_addr  = '0;
    for (int i = 0; i < 12; i++) exp_img[i] = 32'h0;

    // Reset values
    step();
    chk("rst_rd_data_a", rd_data_a, 32'h0);
    chk("rst_rdv_b", {31'd0, rd_data_valid_b}, 32'd0);
    chk("rst_addr_err_a", {31'd0, addr_err_a}, 32'd0);
    chk("rst_wr_ready_a", {31'd0, wr_ready_a}, 32'd0);
    chk("rst_rd_ready_b", {31'd0, rd_ready_b}, 32'd0);
    chk("rst_init_busy_a", {31'd0, init_busy_a}, 32'd1);

    // Reset part-way through INIT restarts the full clear sequence
    reset = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    wait_init();

    read_all();

    // Byte-enable merge
    wr(4'd3, 32'hDEADBEEF, 4'b1111);
    wr(4'd3, 32'h11223344, 4'b0101);
    exp_img[3] = 32'hDE22BE44;
    rd_valid = 1'b1;
    rd_addr  = 4'd3;
    step();
    rd_valid = 1'b0;
    chk("be_rdv_a", {31'd0, rd_data_valid_a}, 32'd1);
    chk("be_data_a", rd_data_a, 32'hDE22BE44);
    chk("be_rdv_b_early", {31'd0, rd_data_valid_b}, 32'd0);
    chk("be_addr_err", {31'd0, addr_err_a}, 32'd0);
    step();
    chk("be_rdv_a_off", {31'd0, rd_data_valid_a}, 32'd0);
    chk("be_hold_a", rd_data_a, 32'hDE22BE44);
    chk("be_rdv_b", {31'd0, rd_data_valid_b}, 32'd1);
    chk("be_data_b", rd_data_b, 32'hDE22BE44);

    // Pipelined reads in order, latency 1 vs 2
    wr(4'd0, 32'hA0, 4'b1111);
    wr(4'd1, 32'hA1, 4'b1111);
    wr(4'd2, 32'hA2, 4'b1111);
    exp_img[0] = 32'hA0;
    exp_img[1] = 32'hA1;
    exp_img[2] = 32'hA2;
    for (int i = 0; i < 5; i++) begin
      rd_valid = (i < 3);
      rd_addr  = 4'(i);
      step();
      chk("pipe_rdv_a", {31'd0, rd_data_valid_a}, {31'd0, i < 3});
      if (i < 3) chk("pipe_data_a", rd_data_a, 32'hA0 + 32'(i));
      chk("pipe_rdv_b", {31'd0, rd_data_valid_b}, {31'd0, (i >= 1) && (i <= 3)});
      if ((i >= 1) && (i <= 3)) chk("pipe_data_b", rd_data_b, 32'hA0 + 32'(i - 1));
    end
    rd_valid = 1'b0;

    // Same-address collision
    wr(4'd5, 32'hFFFFFFFF, 4'b1111);
    wr_valid = 1'b1;
    wr_addr  = 4'd5;
    wr_data  = 32'h55555555;
    wr_be    = 4'b0011;
    rd_valid = 1'b1;
    rd_addr  = 4'd5;
    step();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    exp_img[5] = 32'hFFFF5555;
    chk("coll_rdv_a", {31'd0, rd_data_valid_a}, 32'd1);
    chk("coll_data_a", rd_data_a, 32'hFFFF5555);
    step();
    chk("coll_rdv_b", {31'd0, rd_data_valid_b}, 32'd1);
    chk("coll_data_b", rd_data_b, 32'hFFFFFFFF);

    // Out-of-range write and read together
    wr_valid = 1'b1;
    wr_addr  = 4'd13;
    wr_data  = 32'h12345678;
    wr_be    = 4'b1111;
    rd_valid = 1'b1;
    rd_addr  = 4'd14;
    step();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    chk("oor_err_a", {31'd0, addr_err_a}, 32'd1);
    chk("oor_err_b", {31'd0, addr_err_b}, 32'd1);
    chk("oor_rdv_a", {31'd0, rd_data_valid_a}, 32'd1);
    chk("oor_data_a", rd_data_a, 32'h0);
    step();
    chk("oor_err_a_once", {31'd0, addr_err_a}, 32'd0);
    chk("oor_err_b_once", {31'd0, addr_err_b}, 32'd0);
    chk("oor_rdv_b", {31'd0, rd_data_valid_b}, 32'd1);
    chk("oor_data_b", rd_data_b, 32'h0);
    read_all();

    // Reset in RUN with reads in flight
    rd_valid = 1'b1;
    rd_addr  = 4'd0;
    step();
    rd_addr  = 4'd1;
    step();
    rd_valid = 1'b0;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    chk("mid_rst_rdv_a", {31'd0, rd_data_valid_a}, 32'd0);
    chk("mid_rst_rdv_b", {31'd0, rd_data_valid_b}, 32'd0);
    chk("mid_rst_data_a", rd_data_a, 32'h0);
    chk("mid_rst_data_b", rd_data_b, 32'h0);
    wait_init();
    for (int i = 0; i < 12; i++) exp_img[i] = 32'h0;
    read_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
